counter_seq_ctrl: RTL and testbench

- Command-driven sequencer for the team's up/down counter datapath (direction 0 = up, 1 = down).
- Accepts one command per valid/ready handshake. Then steps a WIDTH-bit count either toward a target (SEEK) or back and forth between 0 and max (PINGPONG).
- Reports completion or abort to the host FSM.

---
 rtl/counter_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for the up/down counter datapath.
// One command per valid/ready handshake; either SEEKs the count toward a target
// one step at a time, or PINGPONGs between 0 and max for a number of endpoint
// arrivals. Reports completion (done) and whether stop ended the run (aborted).
// Optional build macro COUNTER_SEQ_PRESCALE_EN: when defined, a step is taken
// only every PRESCALE cycles while running; otherwise every running cycle steps.
module counter_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int BW       = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [BW-1:0]    cmd_bounces,
    input  logic             stop,
    output logic             direction,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [BW-1:0]    ARR_MAX   = '1;

    // Catch an illegal step period at elaboration rather than in the lab.
    generate
        if (PRESCALE < 1 || PRESCALE > 255) begin : g_prescale_range
            $error("counter_seq_ctrl: PRESCALE must be in 1..255");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [BW-1:0]    bounces_q, bounces_d;
    logic [BW-1:0]    arrivals_q, arrivals_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // Step enable: every running cycle, or once per PRESCALE cycles.
    logic             step_en;
`ifdef COUNTER_SEQ_PRESCALE_EN
    localparam logic [7:0] TICK_LAST = 8'(PRESCALE - 1);
    logic [7:0]       tick_q, tick_d;
    assign step_en = (tick_q == TICK_LAST);
`else
    assign step_en = 1'b1;
`endif

    // Candidate step, computed from the latched command and current position.
    logic             step_dir;
    logic [WIDTH-1:0] step_val;
    logic             land_end;
    logic             dir_after;
    logic [BW-1:0]    arr_after;
    logic             at_goal;
    logic             step_goal;

    // SEEK heads toward the target; PINGPONG keeps its current heading.
    assign step_dir  = mode_q ? dir_q : (count_q > target_q);
    assign step_val  = step_dir ? (count_q - 1'b1) : (count_q + 1'b1);
    // Landing on either endpoint counts as one PINGPONG arrival.
    assign land_end  = (step_val == COUNT_MAX) || (step_val == '0);
    assign dir_after = mode_q ? ((step_val == COUNT_MAX) ? 1'b1 :
                                 (step_val == '0)        ? 1'b0 : dir_q)
                              : step_dir;
    // Arrival counter saturates instead of wrapping.
    assign arr_after = (mode_q && land_end && (arrivals_q != ARR_MAX))
                       ? (arrivals_q + 1'b1) : arrivals_q;
    // Already finished before stepping: covers zero-step commands.
    assign at_goal   = mode_q ? (arrivals_q == bounces_q) : (count_q == target_q);
    // The pending step would finish the command.
    assign step_goal = mode_q ? (land_end && (arr_after == bounces_q))
                              : (step_val == target_q);

    // Next-state and registered-output decode; completion outranks stop.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        target_d   = target_q;
        bounces_d  = bounces_q;
        arrivals_d = arrivals_q;
        aborted_d  = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
        tick_d     = tick_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d    = ST_RUN;
                    mode_d     = cmd_mode;
                    target_d   = cmd_target;
                    bounces_d  = cmd_bounces;
                    arrivals_d = '0;
`ifdef COUNTER_SEQ_PRESCALE_EN
                    tick_d     = 8'd0;
`endif
                    if (cmd_mode) begin
                        // PINGPONG starts upward unless already at max.
                        dir_d = (count_q == COUNT_MAX);
                    end else if (count_q != cmd_target) begin
                        dir_d = (count_q > cmd_target);
                    end
                end
            end
            ST_RUN: begin
`ifdef COUNTER_SEQ_PRESCALE_EN
                tick_d = step_en ? 8'd0 : (tick_q + 8'd1);
`endif
                if (at_goal) begin
                    state_d = ST_DONE;
                end else if (step_en && step_goal) begin
                    count_d    = step_val;
                    dir_d      = dir_after;
                    arrivals_d = arr_after;
                    state_d    = ST_DONE;
                end else if (stop) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (step_en) begin
                    count_d    = step_val;
                    dir_d      = dir_after;
                    arrivals_d = arr_after;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d == ST_RUN);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and registered outputs; rst low clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            dir_q      <= 1'b0;
            mode_q     <= 1'b0;
            target_q   <= '0;
            bounces_q  <= '0;
            arrivals_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
            tick_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            bounces_q  <= bounces_d;
            arrivals_q <= arrivals_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
`ifdef COUNTER_SEQ_PRESCALE_EN
            tick_q     <= tick_d;
`endif
        end
    end

    assign cmd_ready = ready_q;
    assign direction = dir_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: each command pushes its expected
// completion {count, aborted, direction}; a monitor pops on every done pulse.
module tb_counter_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int BW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [WIDTH-1:0] cmd_target;
    logic [BW-1:0]    cmd_bounces;
    logic             stop;
    logic             direction;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             aborted;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(WIDTH), .BW(BW), .PRESCALE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_target  (cmd_target),
        .cmd_bounces (cmd_bounces),
        .stop        (stop),
        .direction   (direction),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             ab;
        logic             dir;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            resp_t a;
            resp_t e;
            a = '{cnt: count, ab: aborted, dir: direction};
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_response", {26'd0, a}, {26'd0, e});
                $display("txn done: count=%0d aborted=%0d dir=%0d (exp %0d/%0d/%0d)",
                         a.cnt, a.ab, a.dir, e.cnt, e.ab, e.dir);
            end
        end
        prev_done = (rst === 1'b1) ? done : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns just after the accepting edge.
    task automatic send(input logic mode, input logic [WIDTH-1:0] tgt,
                        input logic [BW-1:0] bnc, input resp_t exp);
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
        chk("ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_mode    = mode;
        cmd_target  = tgt;
        cmd_bounces = bnc;
        cmd_valid   = 1'b1;
        exp_q.push_back(exp);
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_count(input logic [WIDTH-1:0] val);
        int n;
        n = 0;
        while (count !== val && n < 40) begin
            tick();
            n++;
        end
        chk("reach_count", {28'd0, count}, {28'd0, val});
    endtask

    initial begin
        int c;
        logic [WIDTH-1:0] mc;
        logic             md;

        rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0;
        cmd_target = '0; cmd_bounces = '0; stop = 1'b0;
        tick(); tick();
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("reset_dir",   {31'd0, direction}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_done",  {31'd0, done}, 32'd0);
        chk("reset_abort", {31'd0, aborted}, 32'd0);
        rst = 1'b1;
        tick();
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

`ifdef COUNTER_SEQ_PRESCALE_EN
        // SEEK 0 -> 2 with PRESCALE=4: steps on edges 4 and 8.
        send(1'b0, 4'd2, 4'd0, '{cnt: 4'd2, ab: 1'b0, dir: 1'b0});
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("prescale_count", {28'd0, count}, (k < 4) ? 32'd0 : (k < 8) ? 32'd1 : 32'd2);
        end
        chk("prescale_done", {31'd0, done}, 32'd1);
        tick();
`else
        // SEEK 0 -> 3 to set up the traced run.
        send(1'b0, 4'd3, 4'd0, '{cnt: 4'd3, ab: 1'b0, dir: 1'b0});
        wait_done(40, c);
        chk("seek_0_3_latency", c, 32'd3);
        tick();

        // SEEK 3 -> 7 traced edge by edge.
        send(1'b0, 4'd7, 4'd0, '{cnt: 4'd7, ab: 1'b0, dir: 1'b0});
        chk("accept_busy",  {31'd0, busy}, 32'd1);
        chk("accept_ready", {31'd0, cmd_ready}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("seek_up_count", {28'd0, count}, 32'(3 + k));
            chk("seek_up_dir",   {31'd0, direction}, 32'd0);
            chk("seek_up_done",  {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
        end
        tick();
        chk("seek_up_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("seek_up_done_clear", {31'd0, done}, 32'd0);

        // SEEK 7 -> 2: five down steps.
        send(1'b0, 4'd2, 4'd0, '{cnt: 4'd2, ab: 1'b0, dir: 1'b1});
        wait_done(40, c);
        chk("seek_down_latency", c, 32'd5);
        tick();

        // Zero-step SEEK 2 -> 2: one RUN cycle, direction keeps last step.
        send(1'b0, 4'd2, 4'd0, '{cnt: 4'd2, ab: 1'b0, dir: 1'b1});
        wait_done(40, c);
        chk("seek_zero_latency", c, 32'd1);
        tick();

        send(1'b0, 4'd0, 4'd0, '{cnt: 4'd0, ab: 1'b0, dir: 1'b1});
        wait_done(40, c);
        tick();

        // PINGPONG from 0 with 3 arrivals: 45 steps, ends at 15 heading down.
        send(1'b1, 4'd0, 4'd3, '{cnt: 4'd15, ab: 1'b0, dir: 1'b1});
        mc = 4'd0;
        md = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            mc = md ? (mc - 4'd1) : (mc + 4'd1);
            if (mc == 4'd15) md = 1'b1;
            if (mc == 4'd0)  md = 1'b0;
            chk("pp_count", {28'd0, count}, {28'd0, mc});
            chk("pp_dir",   {31'd0, direction}, {31'd0, md});
            if (k == 44) chk("pp_not_done_early", {31'd0, done}, 32'd0);
        end
        chk("pp_done_at_45", {31'd0, done}, 32'd1);
        tick();

        // PINGPONG bounces=0 at max: no step, one RUN cycle.
        send(1'b1, 4'd0, 4'd0, '{cnt: 4'd15, ab: 1'b0, dir: 1'b1});
        wait_done(40, c);
        chk("pp_zero_latency", c, 32'd1);
        tick();

        // PINGPONG from max starts downward; one arrival at 0.
        send(1'b1, 4'd0, 4'd1, '{cnt: 4'd0, ab: 1'b0, dir: 1'b0});
        wait_done(40, c);
        chk("pp_from_max_latency", c, 32'd15);
        tick();

        // Abort SEEK 0 -> 10 at count 4.
        send(1'b0, 4'd10, 4'd0, '{cnt: 4'd4, ab: 1'b1, dir: 1'b0});
        wait_count(4'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_done",  {31'd0, done}, 32'd1);
        chk("abort_count", {28'd0, count}, 32'd4);
        tick();

        // stop on the completing edge: completion wins.
        send(1'b0, 4'd10, 4'd0, '{cnt: 4'd10, ab: 1'b0, dir: 1'b0});
        wait_count(4'd9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("collide_done",    {31'd0, done}, 32'd1);
        chk("collide_aborted", {31'd0, aborted}, 32'd0);
        tick();

        // stop in IDLE is ignored.
        stop = 1'b1;
        tick(); tick();
        stop = 1'b0;
        chk("idle_stop_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_stop_busy",  {31'd0, busy}, 32'd0);
        chk("idle_stop_count", {28'd0, count}, 32'd10);

        // cmd_valid held through RUN/DONE: next accept only in first IDLE cycle.
        cmd_mode = 1'b0; cmd_target = 4'd8; cmd_valid = 1'b1;
        exp_q.push_back('{cnt: 4'd8, ab: 1'b0, dir: 1'b1});
        exp_q.push_back('{cnt: 4'd12, ab: 1'b0, dir: 1'b0});
        tick();
        cmd_target = 4'd12;
        tick();
        chk("hold_run_count", {28'd0, count}, 32'd9);
        tick();
        chk("hold_done",       {31'd0, done}, 32'd1);
        chk("hold_done_ready", {31'd0, cmd_ready}, 32'd0);
        chk("hold_done_busy",  {31'd0, busy}, 32'd0);
        tick();
        chk("hold_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("hold_idle_busy",  {31'd0, busy}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("hold_accept_busy",  {31'd0, busy}, 32'd1);
        chk("hold_accept_ready", {31'd0, cmd_ready}, 32'd0);
        wait_done(40, c);
        chk("hold_second_latency", c, 32'd4);
        tick();

        // Asynchronous reset mid-RUN at count 5; the command is lost.
        send(1'b0, 4'd0, 4'd0, '{cnt: 4'd0, ab: 1'b0, dir: 1'b1});
        wait_count(4'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", {28'd0, count}, 32'd0);
        chk("async_rst_dir",   {31'd0, direction}, 32'd0);
        chk("async_rst_busy",  {31'd0, busy}, 32'd0);
        chk("async_rst_done",  {31'd0, done}, 32'd0);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        tick();
        chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_release_count", {28'd0, count}, 32'd0);

        send(1'b0, 4'd1, 4'd0, '{cnt: 4'd1, ab: 1'b0, dir: 1'b0});
        wait_done(40, c);
        chk("post_reset_latency", c, 32'd1);
        tick();
`endif
        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
